// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan driver:
// active-low segment encodings ([6]=a .. [0]=g) and index-width sizing.
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_HEX [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  function automatic seg_t hex_to_seg(input nibble_t nib);
    return SEG_HEX[nib];
  endfunction

  // A single-digit build still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Control-side data inputs and display-pin outputs of the scan driver.
// master = control logic / board pins, slave = the driver itself.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digit_val;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blink_in;
  logic [6:0]              cathode;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output load, digit_val, digit_en, dp_in, blink_in,
    input  cathode, dp_n, an, frame_start
  );

  modport slave (
    input  load, digit_val, digit_en, dp_in, blink_in,
    output cathode, dp_n, an, frame_start
  );
endinterface

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the current digit's segment pattern.
  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: slot/digit/blink counters, a pending
// buffer swapped into the display shadow only at frame boundaries, registered pins.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input logic               clk,
  input logic               reset,
  seg7_scan_driver_if.slave bus
);

  localparam int IDX_W   = idx_width(NUM_DIGITS);
  localparam int SCAN_W  = $clog2(REFRESH_DIV);
  localparam int BLINK_W = (BLINK_FRAMES <= 1) ? 1 : $clog2(BLINK_FRAMES);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(REFRESH_DIV - 1);
  localparam logic [SCAN_W-1:0]  SCAN_ONE   = SCAN_W'(1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

  logic [SCAN_W-1:0]       scan_cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [BLINK_W-1:0]      blink_cnt_r;
  logic                    blink_phase_r;

  logic                    pending_r;
  logic [4*NUM_DIGITS-1:0] pend_val_r;
  logic [NUM_DIGITS-1:0]   pend_en_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r;
  logic [NUM_DIGITS-1:0]   pend_blink_r;
  logic [4*NUM_DIGITS-1:0] shd_val_r;
  logic [NUM_DIGITS-1:0]   shd_en_r;
  logic [NUM_DIGITS-1:0]   shd_dp_r;
  logic [NUM_DIGITS-1:0]   shd_blink_r;

  logic [6:0]              cathode_r;
  logic                    dp_n_r;
  logic [NUM_DIGITS-1:0]   an_r;
  logic                    frame_start_r;

  logic                    slot_wrap_s;
  logic                    frame_wrap_s;
  logic                    lit_s;
  logic [3:0]              cur_nib_s;
  logic [6:0]              dec_seg_s;
  logic [NUM_DIGITS-1:0]   an_nxt_s;

  assign slot_wrap_s  = (scan_cnt_r == SCAN_LAST);
  assign frame_wrap_s = slot_wrap_s && (idx_r == IDX_LAST);
  assign cur_nib_s    = shd_val_r[{idx_r, 2'b00} +: 4];

  // scan_cnt == 0 is the dead cycle of every slot, so a lit digit never overlaps a neighbour.
  assign lit_s = (scan_cnt_r != {SCAN_W{1'b0}}) && shd_en_r[idx_r]
                 && !(shd_blink_r[idx_r] && blink_phase_r);

  seg7_decoder u_decoder (
    .nibble (cur_nib_s),
    .seg    (dec_seg_s)
  );

  // Next anode pattern: only the current digit's anode pulled low when lit.
  always_comb begin
    an_nxt_s = {NUM_DIGITS{1'b1}};
    if (lit_s) begin
      an_nxt_s[idx_r] = 1'b0;
    end else begin
      an_nxt_s = {NUM_DIGITS{1'b1}};
    end
  end

  // Slot counter and digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt_r <= {SCAN_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
    end else if (slot_wrap_s) begin
      scan_cnt_r <= {SCAN_W{1'b0}};
      idx_r      <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : (idx_r + IDX_ONE);
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_ONE;
    end
  end

  // Frame counter driving the blink half-period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_r   <= {BLINK_W{1'b0}};
      blink_phase_r <= 1'b0;
    end else if (frame_wrap_s) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r   <= {BLINK_W{1'b0}};
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BLINK_ONE;
      end
    end
  end

  // Double buffer: a load on the boundary cycle bypasses pending straight into shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r    <= 1'b0;
      pend_val_r   <= {(4*NUM_DIGITS){1'b0}};
      pend_en_r    <= {NUM_DIGITS{1'b0}};
      pend_dp_r    <= {NUM_DIGITS{1'b0}};
      pend_blink_r <= {NUM_DIGITS{1'b0}};
      shd_val_r    <= {(4*NUM_DIGITS){1'b0}};
      shd_en_r     <= {NUM_DIGITS{1'b0}};
      shd_dp_r     <= {NUM_DIGITS{1'b0}};
      shd_blink_r  <= {NUM_DIGITS{1'b0}};
    end else if (bus.load && frame_wrap_s) begin
      pending_r   <= 1'b0;
      shd_val_r   <= bus.digit_val;
      shd_en_r    <= bus.digit_en;
      shd_dp_r    <= bus.dp_in;
      shd_blink_r <= bus.blink_in;
    end else if (bus.load) begin
      pending_r    <= 1'b1;
      pend_val_r   <= bus.digit_val;
      pend_en_r    <= bus.digit_en;
      pend_dp_r    <= bus.dp_in;
      pend_blink_r <= bus.blink_in;
    end else if (frame_wrap_s && pending_r) begin
      pending_r   <= 1'b0;
      shd_val_r   <= pend_val_r;
      shd_en_r    <= pend_en_r;
      shd_dp_r    <= pend_dp_r;
      shd_blink_r <= pend_blink_r;
    end
  end

  // Registered pins; cathode and anode update together in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cathode_r     <= SEG_BLANK;
      dp_n_r        <= 1'b1;
      an_r          <= {NUM_DIGITS{1'b1}};
      frame_start_r <= 1'b0;
    end else begin
      cathode_r     <= lit_s ? dec_seg_s : SEG_BLANK;
      dp_n_r        <= lit_s ? ~shd_dp_r[idx_r] : 1'b1;
      an_r          <= an_nxt_s;
      frame_start_r <= (scan_cnt_r == {SCAN_W{1'b0}}) && (idx_r == {IDX_W{1'b0}});
    end
  end

  assign bus.cathode     = cathode_r;
  assign bus.dp_n        = dp_n_r;
  assign bus.an          = an_r;
  assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (4 digits, 4-cycle slots, 2-frame blink): per-cycle
// reference model from frame arithmetic, a vector table and targeted sequences.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int BF    = 2;
  localparam int FRAME = N * R;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus_if ();

  seg7_scan_driver #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;
  int tick   = 0;

  logic [6:0] hex_seg [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  // displayed data (m_*) and latest not-yet-shown load (p_*)
  logic [15:0] m_val, p_val;
  logic [3:0]  m_en, m_dp, m_bl, p_en, p_dp, p_bl;
  bit          p_valid;

  typedef struct packed {
    logic [15:0]     val;
    logic [3:0]      en;
    logic [3:0]      dp;
    logic [3:0][3:0] exp_an;
    logic [3:0][6:0] exp_cath;
    logic [3:0]      exp_dpn;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s tick=%0d actual=%h required=%h", name, tick, act, exp);
    end
  endtask

  task automatic model_expect(input int t, output logic [3:0] e_an, output logic [6:0] e_cath,
                              output logic e_dpn, output logic e_fs);
    int s, i, f;
    bit phase, lit;
    s     = t % R;
    i     = (t / R) % N;
    f     = t / FRAME;
    phase = ((f / BF) % 2) == 1;
    lit   = (s != 0) && m_en[i] && !(m_bl[i] && phase);
    e_an   = 4'hF;
    e_cath = 7'h7F;
    e_dpn  = 1'b1;
    if (lit) begin
      e_an[i] = 1'b0;
      e_cath  = hex_seg[m_val[i*4 +: 4]];
      e_dpn   = ~m_dp[i];
    end
    e_fs = (t % FRAME) == 0;
  endtask

  task automatic model_clear();
    m_val = 16'h0; m_en = 4'h0; m_dp = 4'h0; m_bl = 4'h0;
    p_val = 16'h0; p_en = 4'h0; p_dp = 4'h0; p_bl = 4'h0;
    p_valid = 1'b0;
    tick = 0;
  endtask

  task automatic step();
    bit ld;
    logic [15:0] v;
    logic [3:0] en, dp, bl, e_an;
    logic [6:0] e_cath;
    logic e_dpn, e_fs;
    ld = bus_if.load; v = bus_if.digit_val; en = bus_if.digit_en;
    dp = bus_if.dp_in; bl = bus_if.blink_in;
    @(posedge clk);
    #1;
    model_expect(tick, e_an, e_cath, e_dpn, e_fs);
    check("an", 32'(bus_if.an), 32'(e_an));
    check("cathode", 32'(bus_if.cathode), 32'(e_cath));
    check("dp_n", 32'(bus_if.dp_n), 32'(e_dpn));
    check("frame_start", 32'(bus_if.frame_start), 32'(e_fs));
    if (ld) begin
      p_val = v; p_en = en; p_dp = dp; p_bl = bl; p_valid = 1'b1;
    end
    tick++;
    if ((tick % FRAME) == 0 && p_valid) begin
      m_val = p_val; m_en = p_en; m_dp = p_dp; m_bl = p_bl; p_valid = 1'b0;
    end
    bus_if.load = 1'b0;
  endtask

  task automatic set_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] dp,
                          input logic [3:0] bl);
    bus_if.load = 1'b1; bus_if.digit_val = v; bus_if.digit_en = en;
    bus_if.dp_in = dp; bus_if.blink_in = bl;
  endtask

  task automatic sync_to(input int ph);
    int guard = 0;
    while ((tick % FRAME) != ph && guard < 2 * FRAME) begin
      step();
      guard++;
    end
    check("sync_bound", 32'(tick % FRAME), 32'(ph));
  endtask

  task automatic do_reset();
    bus_if.load = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_an", 32'(bus_if.an), 32'h0000000F);
    check("rst_cathode", 32'(bus_if.cathode), 32'h0000007F);
    check("rst_dp_n", 32'(bus_if.dp_n), 32'h00000001);
    check("rst_frame_start", 32'(bus_if.frame_start), 32'h00000000);
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_an", 32'(bus_if.an), 32'h0000000F);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    int cnt;
    int exp_lit [6];
    reset = 1'b1;
    bus_if.load = 1'b0; bus_if.digit_val = 16'h0; bus_if.digit_en = 4'h0;
    bus_if.dp_in = 4'h0; bus_if.blink_in = 4'h0;
    model_clear();

    tbl[0] = '{16'h3210, 4'hF, 4'h0, {4'h7, 4'hB, 4'hD, 4'hE},
               {7'h06, 7'h12, 7'h4F, 7'h01}, 4'b1111};
    tbl[1] = '{16'h7654, 4'b1010, 4'b0010, {4'h7, 4'hF, 4'hD, 4'hF},
               {7'h0F, 7'h7F, 7'h24, 7'h7F}, 4'b1101};
    tbl[2] = '{16'hBA98, 4'hF, 4'b1001, {4'h7, 4'hB, 4'hD, 4'hE},
               {7'h60, 7'h08, 7'h04, 7'h00}, 4'b0110};
    tbl[3] = '{16'hFEDC, 4'hF, 4'h0, {4'h7, 4'hB, 4'hD, 4'hE},
               {7'h38, 7'h30, 7'h42, 7'h31}, 4'b1111};
    tbl[4] = '{16'h0000, 4'b0100, 4'hF, {4'hF, 4'hB, 4'hF, 4'hF},
               {7'h7F, 7'h01, 7'h7F, 7'h7F}, 4'b1011};

    do_reset();

    // idle: nothing lit, frame_start every 16 cycles
    for (int k = 0; k < 64; k++) step();

    // table vectors, each shown in the frame after its load
    for (int v = 0; v < 5; v++) begin
      sync_to(3 + v);
      set_load(tbl[v].val, tbl[v].en, tbl[v].dp, 4'h0);
      step();
      sync_to(0);
      for (int d = 0; d < N; d++) begin
        for (int s = 0; s < R; s++) begin
          step();
          if (s == 0) check("tbl_dead_an", 32'(bus_if.an), 32'h0000000F);
          if (s == 2) begin
            check("tbl_an", 32'(bus_if.an), 32'(tbl[v].exp_an[d]));
            check("tbl_cathode", 32'(bus_if.cathode), 32'(tbl[v].exp_cath[d]));
            check("tbl_dp_n", 32'(bus_if.dp_n), 32'(tbl[v].exp_dpn[d]));
          end
        end
      end
    end

    // repeated loads in one frame: only the last is shown
    sync_to(5);
    set_load(16'h1111, 4'hF, 4'h0, 4'h0);
    step();
    sync_to(10);
    set_load(16'h2222, 4'hF, 4'h0, 4'h0);
    step();
    sync_to(0);
    step(); step(); step();
    check("last_load_wins", 32'(bus_if.cathode), 32'h00000012);

    // load on the exact boundary cycle appears in the very next frame
    sync_to(FRAME - 1);
    set_load(16'h8888, 4'hF, 4'h0, 4'h0);
    step();
    step(); step(); step();
    check("boundary_load", 32'(bus_if.cathode), 32'h00000000);

    // blink on digit 0: lit cycles per frame after a load at tick 0
    do_reset();
    set_load(16'h3210, 4'hF, 4'h0, 4'b0001);
    for (int k = 0; k < FRAME; k++) step();
    exp_lit = '{0, 3, 0, 0, 3, 3};
    for (int f = 1; f < 6; f++) begin
      cnt = 0;
      for (int k = 0; k < FRAME; k++) begin
        step();
        if (bus_if.an[0] == 1'b0) cnt++;
      end
      check("blink_lit_cycles", 32'(cnt), 32'(exp_lit[f]));
    end

    // asynchronous reset during a digit 2 slot
    sync_to(2 * R + 2);
    step();
    check("pre_reset_an", 32'(bus_if.an), 32'h0000000B);
    #2;
    do_reset();
    for (int k = 0; k < 2 * FRAME; k++) step();

    // randomized loads against the reference model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 5) == 0)
        set_load(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
